// File: rtl/game_input_tick.sv
// ============================================================================
// Module   : game_input_tick
// Purpose  : Time-base strobes and synchronised/debounced button conditioning
// Revision : 1.0
// ============================================================================
`default_nettype none

module game_input_tick #(
  parameter int BLOCK_DIV = 100_000_000,
  parameter int LASER_DIV = 10_000_000,
  parameter int MOVE_DIV  = 25_000_000,
  parameter int DB_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic freeze_i,
  input  logic btn_adj_raw_i,
  input  logic btn_lr_raw_i,
  input  logic btn_shoot_raw_i,
  output logic block_clk_o,
  output logic laser_clk_o,
  output logic player_move_clk_o,
  output logic btn_adj_o,
  output logic btn_left_right_o,
  output logic btn_shoot_o
);

  localparam int c_NUM_TICKS = 3;
  localparam int c_NUM_BTNS  = 3;
  localparam int c_DB_W      = $clog2(DB_CYCLES + 1);
  localparam logic [c_DB_W-1:0] c_DB_LAST = c_DB_W'(DB_CYCLES - 1);

  logic [c_NUM_TICKS-1:0] w_strobe;
  logic [c_NUM_BTNS-1:0]  w_raw;
  logic [c_NUM_BTNS-1:0]  w_stable;

  assign w_raw = {btn_shoot_raw_i, btn_lr_raw_i, btn_adj_raw_i};

  // Index 0 = block, 1 = laser, 2 = player move.
  generate
    for (genvar gi = 0; gi < c_NUM_TICKS; gi++) begin : g_tick
      localparam int c_DIV = (gi == 0) ? BLOCK_DIV :
                             (gi == 1) ? LASER_DIV : MOVE_DIV;
      localparam int c_W   = $clog2(c_DIV);
      localparam logic [c_W-1:0] c_LAST = c_W'(c_DIV - 1);

      logic [c_W-1:0] cnt_q;
      logic [c_W-1:0] cnt_d;
      logic           strobe_q;
      logic           strobe_d;

      always_comb begin
        cnt_d    = cnt_q;
        strobe_d = 1'b0;
        if (!freeze_i) begin
          if (cnt_q == c_LAST) begin
            cnt_d    = '0;
            strobe_d = 1'b1;
          end else begin
            cnt_d    = cnt_q + c_W'(1);
          end
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          cnt_q    <= '0;
          strobe_q <= 1'b0;
        end else begin
          cnt_q    <= cnt_d;
          strobe_q <= strobe_d;
        end
      end

      assign w_strobe[gi] = strobe_q;
    end
  endgenerate

  // Index 0 = adj, 1 = left/right, 2 = shoot; freeze deliberately ignored here.
  generate
    for (genvar gb = 0; gb < c_NUM_BTNS; gb++) begin : g_btn
      logic              s1_q;
      logic              s2_q;
      logic              stable_q;
      logic              stable_d;
      logic [c_DB_W-1:0] cnt_q;
      logic [c_DB_W-1:0] cnt_d;

      always_comb begin
        stable_d = stable_q;
        cnt_d    = '0;
        if (s2_q != stable_q) begin
          if (cnt_q == c_DB_LAST) begin
            stable_d = s2_q;
          end else begin
            cnt_d    = cnt_q + c_DB_W'(1);
          end
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          s1_q     <= 1'b0;
          s2_q     <= 1'b0;
          stable_q <= 1'b0;
          cnt_q    <= '0;
        end else begin
          s1_q     <= w_raw[gb];
          s2_q     <= s1_q;
          stable_q <= stable_d;
          cnt_q    <= cnt_d;
        end
      end

      assign w_stable[gb] = stable_q;
    end
  endgenerate

  logic shoot_dly_q;
  logic shoot_pulse_q;
  logic shoot_pulse_d;

  assign shoot_pulse_d = w_stable[2] & ~shoot_dly_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      shoot_dly_q   <= 1'b0;
      shoot_pulse_q <= 1'b0;
    end else begin
      shoot_dly_q   <= w_stable[2];
      shoot_pulse_q <= shoot_pulse_d;
    end
  end

  assign block_clk_o       = w_strobe[0];
  assign laser_clk_o       = w_strobe[1];
  assign player_move_clk_o = w_strobe[2];
  assign btn_adj_o         = w_stable[0];
  assign btn_left_right_o  = w_stable[1];
  assign btn_shoot_o       = shoot_pulse_q;

endmodule

`default_nettype wire

// File: tb/tb_game_input_tick.sv
// ============================================================================
// Module   : tb_game_input_tick
// Purpose  : Scenario and randomised checks of game_input_tick against a model
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_game_input_tick;

  localparam int c_BLOCK = 10;
  localparam int c_LASER = 3;
  localparam int c_MOVE  = 5;
  localparam int c_DB    = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic freeze = 1'b0;
  logic raw_adj = 1'b0;
  logic raw_lr = 1'b0;
  logic raw_shoot = 1'b0;
  logic block_clk, laser_clk, move_clk, btn_adj, btn_lr, btn_shoot;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  game_input_tick #(
    .BLOCK_DIV(c_BLOCK), .LASER_DIV(c_LASER), .MOVE_DIV(c_MOVE), .DB_CYCLES(c_DB)
  ) dut (
    .clk(clk), .rst(rst), .freeze_i(freeze),
    .btn_adj_raw_i(raw_adj), .btn_lr_raw_i(raw_lr), .btn_shoot_raw_i(raw_shoot),
    .block_clk_o(block_clk), .laser_clk_o(laser_clk), .player_move_clk_o(move_clk),
    .btn_adj_o(btn_adj), .btn_left_right_o(btn_lr), .btn_shoot_o(btn_shoot)
  );

  logic [5:0] dut_out;
  assign dut_out = {block_clk, laser_clk, move_clk, btn_adj, btn_lr, btn_shoot};

  // Reference model: strobes from a count of unfrozen edges since reset,
  // levels flip once the last DB synchronised samples all disagree.
  int            m_act = 0;
  logic          m_p1 [3];
  logic          m_p2 [3];
  logic          m_st [3];
  logic [c_DB-1:0] m_win [3];
  int            m_fill [3];
  logic          m_sdly = 1'b0;
  logic [5:0]    m_out = 6'b0;

  task automatic model_edge();
    logic       raw [3];
    logic       nst [3];
    logic [2:0] s;
    logic       pulse;
    logic       seen;
    raw[0] = raw_adj; raw[1] = raw_lr; raw[2] = raw_shoot;
    if (rst) begin
      m_act = 0; m_sdly = 1'b0; m_out = '0;
      for (int b = 0; b < 3; b++) begin
        m_p1[b] = 1'b0; m_p2[b] = 1'b0; m_st[b] = 1'b0; m_win[b] = '0; m_fill[b] = 0;
      end
    end else begin
      s = 3'b000;
      if (!freeze) begin
        m_act++;
        s[2] = (m_act % c_BLOCK) == 0;
        s[1] = (m_act % c_LASER) == 0;
        s[0] = (m_act % c_MOVE) == 0;
      end
      for (int b = 0; b < 3; b++) begin
        seen = m_p2[b];
        m_p2[b] = m_p1[b];
        m_p1[b] = raw[b];
        m_win[b] = {m_win[b][c_DB-2:0], seen};
        if (m_fill[b] < c_DB) m_fill[b]++;
        nst[b] = m_st[b];
        if (m_fill[b] == c_DB && m_win[b] == {c_DB{~m_st[b]}}) nst[b] = ~m_st[b];
      end
      pulse = m_st[2] & ~m_sdly;
      m_sdly = m_st[2];
      for (int b = 0; b < 3; b++) m_st[b] = nst[b];
      m_out = {s, m_st[0], m_st[1], pulse};
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic test_reset();
    int first_blk;
    rst = 1'b1; freeze = 1'b0; raw_adj = 0; raw_lr = 0; raw_shoot = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      n_cmp++;
      if (dut_out !== 6'b0) begin
        n_bad++; $display("FAIL reset_outputs got=%b want=000000", dut_out);
      end
    end
    rst = 1'b0;
    cyc = 0;
    first_blk = -1;
    for (int i = 0; i < 35; i++) begin
      step();
      if (block_clk === 1'b1 && first_blk < 0) first_blk = cyc;
      n_cmp++;
      if (dut_out !== m_out) begin
        n_bad++; $display("FAIL reset_run cyc=%0d got=%b want=%b", cyc, dut_out, m_out);
      end
      if (cyc == 30) begin
        n_cmp++;
        if (dut_out[5:3] !== 3'b111) begin
          n_bad++; $display("FAIL coincident_c30 got=%b want=111", dut_out[5:3]);
        end
      end
    end
    n_cmp++;
    if (first_blk !== 10) begin
      n_bad++; $display("FAIL first_block got=%0d want=10", first_blk);
    end
  endtask

  task automatic test_debounce();
    int lat;
    lat = -1;
    raw_lr = 1'b1;
    for (int n = 1; n <= 20; n++) begin
      step();
      n_cmp++;
      if (dut_out !== m_out) begin
        n_bad++; $display("FAIL db_model got=%b want=%b", dut_out, m_out);
      end
      if (btn_lr === 1'b1) begin lat = n; break; end
    end
    n_cmp++;
    if (lat !== c_DB + 2) begin
      n_bad++; $display("FAIL db_latency got=%0d want=%0d", lat, c_DB + 2);
    end
    raw_lr = 1'b0;
    for (int i = 0; i < 10; i++) step();
    n_cmp++;
    if (btn_lr !== 1'b0) begin
      n_bad++; $display("FAIL db_release got=%b want=0", btn_lr);
    end
    raw_lr = 1'b1;
    for (int i = 0; i < 3; i++) step();
    raw_lr = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      n_cmp++;
      if (btn_lr !== 1'b0 || dut_out !== m_out) begin
        n_bad++; $display("FAIL db_glitch got=%b want=%b", dut_out, m_out);
      end
    end
  endtask

  task automatic test_shoot();
    int pulses;
    int at;
    pulses = 0; at = -1;
    raw_shoot = 1'b1;
    for (int n = 1; n <= 20; n++) begin
      step();
      if (btn_shoot === 1'b1) begin pulses++; if (at < 0) at = n; end
    end
    n_cmp++;
    if (pulses !== 1 || at !== c_DB + 3) begin
      n_bad++; $display("FAIL shoot_press pulses=%0d at=%0d want 1 at %0d", pulses, at, c_DB + 3);
    end
    raw_shoot = 1'b0;
    pulses = 0;
    for (int n = 1; n <= 15; n++) begin
      step();
      if (btn_shoot === 1'b1) pulses++;
    end
    n_cmp++;
    if (pulses !== 0) begin
      n_bad++; $display("FAIL shoot_release pulses=%0d want=0", pulses);
    end
  endtask

  task automatic test_freeze();
    bit found;
    int lat;
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      step();
      if (laser_clk === 1'b1) found = 1;
    end
    n_cmp++;
    if (!found) begin
      n_bad++; $display("FAIL freeze_align got=no_laser want=laser_strobe");
    end
    step();
    freeze = 1'b1;
    for (int i = 0; i < 7; i++) begin
      step();
      n_cmp++;
      if (dut_out[5:3] !== 3'b000) begin
        n_bad++; $display("FAIL freeze_quiet got=%b want=000", dut_out[5:3]);
      end
    end
    freeze = 1'b0;
    lat = -1;
    for (int n = 1; n <= 6; n++) begin
      step();
      if (laser_clk === 1'b1) begin lat = n; break; end
    end
    n_cmp++;
    if (lat !== 2) begin
      n_bad++; $display("FAIL freeze_resume got=%0d want=2", lat);
    end
    lat = -1;
    for (int n = 1; n <= 6; n++) begin
      step();
      if (laser_clk === 1'b1) begin lat = n; break; end
    end
    n_cmp++;
    if (lat !== c_LASER) begin
      n_bad++; $display("FAIL freeze_period got=%0d want=%0d", lat, c_LASER);
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    raw_adj = 1'b1;
    step(); step();
    rst = 1'b1;
    step();
    n_cmp++;
    if (dut_out !== 6'b0) begin
      n_bad++; $display("FAIL midrst_outputs got=%b want=000000", dut_out);
    end
    rst = 1'b0;
    lat = -1;
    for (int n = 1; n <= 20; n++) begin
      step();
      if (btn_adj === 1'b1) begin lat = n; break; end
    end
    n_cmp++;
    if (lat !== c_DB + 2) begin
      n_bad++; $display("FAIL midrst_latency got=%0d want=%0d", lat, c_DB + 2);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 7) == 0) freeze = ~freeze;
      if ($urandom_range(0, 4) == 0) raw_adj = ~raw_adj;
      if ($urandom_range(0, 5) == 0) raw_lr = ~raw_lr;
      if ($urandom_range(0, 6) == 0) raw_shoot = ~raw_shoot;
      step();
      n_cmp++;
      if (dut_out !== m_out) begin
        n_bad++; $display("FAIL random i=%0d got=%b want=%b", i, dut_out, m_out);
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_debounce();
    test_shoot();
    test_freeze();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
